// File: rtl/alu_pkg.sv
// Shared types and reset constants for the 6502-style ALU.
package alu_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned NIB_W  = 4;

  typedef enum logic [2:0] {
    OP_SUMS = 3'd0,
    OP_ANDS = 3'd1,
    OP_EORS = 3'd2,
    OP_ORS  = 3'd3,
    OP_SRS  = 3'd4
  } alu_op_t;

  typedef struct packed {
    logic acr;
    logic avr;
    logic hc;
  } alu_flags_t;

  localparam logic [DATA_W-1:0] RST_OPERAND = '0;
  localparam alu_op_t           RST_OP      = OP_SUMS;
  localparam logic              RST_CIN     = 1'b0;
  localparam logic              RST_DAA     = 1'b0;
  localparam alu_flags_t        RST_FLAGS   = '0;

  // Fixed priority among the operation strobes; holds when none is set.
  function automatic alu_op_t sel_op(
    input logic    sums,
    input logic    ands,
    input logic    eors,
    input logic    ors,
    input logic    srs,
    input alu_op_t hold
  );
    alu_op_t op;
    op = hold;
    if (sums)      op = OP_SUMS;
    else if (ands) op = OP_ANDS;
    else if (eors) op = OP_EORS;
    else if (ors)  op = OP_ORS;
    else if (srs)  op = OP_SRS;
    return op;
  endfunction

endpackage

// File: rtl/alu_bcd_adjust.sv
// Combinational BCD corrector for SUMS results; only built when DECIMAL_MODE_EN is defined.
`ifdef DECIMAL_MODE_EN
module alu_bcd_adjust
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] sum_i,
  input  logic              carry_i,
  input  logic              half_i,
  output logic [DATA_W-1:0] result_o,
  output logic              carry_o
);

  logic [DATA_W:0] low_fix;
  logic            hi_adj;

  // Low nibble first, then the high nibble judged on the intermediate value.
  always_comb begin
    low_fix = {1'b0, sum_i};
    if ((sum_i[NIB_W-1:0] > 4'd9) || half_i) begin
      low_fix = low_fix + (DATA_W+1)'(6);
    end
    hi_adj   = (low_fix > (DATA_W+1)'(9'h099)) || carry_i;
    result_o = hi_adj ? (low_fix[DATA_W-1:0] + DATA_W'(8'h60)) : low_fix[DATA_W-1:0];
    carry_o  = carry_i | hi_adj;
  end

endmodule
`endif

// File: rtl/alu_core.sv
// 8-bit 6502-style ALU: latched operands/op, combinational result, registered flags.
// Decimal adjust of SUMS is present only when DECIMAL_MODE_EN is defined.
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             phi_2,
  input  logic             res_n,
  input  logic [WIDTH-1:0] sb_bus,
  input  logic [WIDTH-1:0] db_bus,
  input  logic [WIDTH-1:0] adl_bus,
  input  logic             sb_add,
  input  logic             zero_add,
  input  logic             db_add,
  input  logic             db_n_add,
  input  logic             adl_add,
  input  logic             i_addc,
  input  logic             sums,
  input  logic             ands,
  input  logic             eors,
  input  logic             ors,
  input  logic             srs,
  input  logic             daa,
  output logic [WIDTH-1:0] alu_to_add,
  output logic             acr,
  output logic             avr,
  output logic             hc
);

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  alu_op_t          op_q, op_d;
  logic             cin_q;
  alu_flags_t       flags_q;
  alu_flags_t       flags_c;
  logic [WIDTH-1:0] result_c;
  logic [WIDTH:0]   sum_full_c;
  logic [NIB_W:0]   low_sum_c;

  // Operand loads behave like a wired-AND of every selected source.
  always_comb begin
    a_d = a_q;
    if (sb_add || zero_add) begin
      a_d = '1;
      if (sb_add)   a_d = a_d & sb_bus;
      if (zero_add) a_d = '0;
    end
    b_d = b_q;
    if (db_add || db_n_add || adl_add) begin
      b_d = '1;
      if (db_add)   b_d = b_d & db_bus;
      if (db_n_add) b_d = b_d & ~db_bus;
      if (adl_add)  b_d = b_d & adl_bus;
    end
    op_d = sel_op(sums, ands, eors, ors, srs, op_q);
  end

  always_ff @(posedge phi_2) begin
    if (!res_n) begin
      a_q     <= RST_OPERAND;
      b_q     <= RST_OPERAND;
      op_q    <= RST_OP;
      cin_q   <= RST_CIN;
      flags_q <= RST_FLAGS;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      cin_q   <= i_addc;
      flags_q <= flags_c;
    end
  end

  assign sum_full_c = {1'b0, a_q} + {1'b0, b_q} + (WIDTH+1)'(cin_q);
  assign low_sum_c  = {1'b0, a_q[NIB_W-1:0]} + {1'b0, b_q[NIB_W-1:0]} + (NIB_W+1)'(cin_q);

`ifdef DECIMAL_MODE_EN
  logic             daa_q;
  logic [WIDTH-1:0] bcd_result;
  logic             bcd_carry;

  always_ff @(posedge phi_2) begin
    if (!res_n) daa_q <= RST_DAA;
    else        daa_q <= daa;
  end

  alu_bcd_adjust u_bcd (
    .sum_i    (sum_full_c[WIDTH-1:0]),
    .carry_i  (sum_full_c[WIDTH]),
    .half_i   (low_sum_c[NIB_W]),
    .result_o (bcd_result),
    .carry_o  (bcd_carry)
  );
`else
  logic unused_daa;
  assign unused_daa = daa;
`endif

  // Result and flag values from the latched state; overflow stays binary.
  always_comb begin
    result_c = '0;
    flags_c  = '0;
    case (op_q)
      OP_SUMS: begin
        result_c    = sum_full_c[WIDTH-1:0];
        flags_c.acr = sum_full_c[WIDTH];
        flags_c.hc  = low_sum_c[NIB_W];
        flags_c.avr = (a_q[WIDTH-1] ~^ b_q[WIDTH-1]) & (a_q[WIDTH-1] ^ sum_full_c[WIDTH-1]);
`ifdef DECIMAL_MODE_EN
        if (daa_q) begin
          result_c    = bcd_result;
          flags_c.acr = bcd_carry;
        end
`endif
      end
      OP_ANDS: result_c = a_q & b_q;
      OP_EORS: result_c = a_q ^ b_q;
      OP_ORS:  result_c = a_q | b_q;
      OP_SRS: begin
        result_c    = {cin_q, a_q[WIDTH-1:1]};
        flags_c.acr = a_q[0];
      end
      default: begin
        result_c = '0;
        flags_c  = '0;
      end
    endcase
  end

  assign alu_to_add = result_c;
  assign acr        = flags_q.acr;
  assign avr        = flags_q.avr;
  assign hc         = flags_q.hc;

endmodule

// File: doc/alu_core.md
Name: alu_core

Overview:
- 8-bit 6502-style ALU that sits directly upstream of the adder hold register.
- Latches its A and B operands, the operation select and carry-in from the internal buses on the rising edge of phi_2.
- Drives the combinational result alu_to_add, which the adder hold register captures on the following falling edge.
- Also produces the ACR (carry), AVR (overflow) and HC (half-carry) flags consumed by the flag and branch logic.

Parameters:
- WIDTH, 8, datapath width. Only 8 is supported; the nibble logic assumes 8.

Ports:
- phi_2  in  1  system clock; all state updates on the rising edge.
- res_n  in  1  synchronous active-low reset.
- sb_bus  in  8  special bus, source for operand A.
- db_bus  in  8  data bus, source for operand B (true or inverted).
- adl_bus  in  8  address-low bus, source for operand B.
- sb_add  in  1  load A from sb_bus.
- zero_add  in  1  load A with 0x00.
- db_add  in  1  load B from db_bus.
- db_n_add  in  1  load B from ~db_bus.
- adl_add  in  1  load B from adl_bus.
- i_addc  in  1  carry-in, latched with the operands.
- sums, ands, eors, ors, srs  in  1 each  operation select.
- daa  in  1  decimal adjust for SUMS.
- alu_to_add  out  8  result, combinational from the latched state.
- acr  out  1  carry-out, registered.
- avr  out  1  overflow, registered.
- hc  out  1  half-carry, registered.

Behaviour:
Reset:
- When res_n is 0 at a rising edge: A=0x00, B=0x00, op=SUMS, cin=0, daa_q=0, acr=avr=hc=0.
- alu_to_add therefore reads 0x00 after reset.
- Reset wins over every load strobe, including in the cycle it deasserts.

Operand A:
- A loads when sb_add or zero_add is set.
- If both are set, A gets sb_bus & 0x00 = 0x00 (wired-AND bus semantics).
- If neither is set, A holds.

Operand B:
- B loads when any of db_add, db_n_add or adl_add is set.
- B becomes the bitwise AND of all selected sources.
- If none is set, B holds.

Operation select:
- op is latched only when at least one select is set.
- Priority when several are set: sums > ands > eors > ors > srs.
- If no select is set, op holds.
- i_addc and daa are latched every cycle.

Result (combinational from the latched A, B, op, cin, daa_q):
- SUMS: A + B + cin. Bits 7:0 form the result; bit 8 is the carry.
- ANDS: A & B.
- EORS: A ^ B.
- ORS: A | B.
- SRS: {cin, A[7:1]}; carry = A[0].
- Half-carry: the carry out of bit 3 in SUMS, otherwise 0.
- Overflow: (A[7] ~^ B[7]) & (A[7] ^ sum[7]) in SUMS, otherwise 0. It is always the binary value, even with decimal adjust.

Flags:
- acr, avr and hc register the combinational flag values at each rising edge.
- They therefore reflect the operand set latched one cycle earlier (latency 1).
- alu_to_add has latency 0 from the latched state.
- Downstream timing: operands latch at rising edge N, alu_to_add is valid before falling edge N, and the flags are valid after rising edge N+1.
- Operand reload and flag capture in the same cycle are legal: the flags capture the old state.

Wrap-around:
- Results are modulo 256.
- Worked example: 0xFF + 0x01 gives 0x00 with carry=1.

Optional Feature:
- Macro: DECIMAL_MODE_EN.
- Defined, when daa_q=1 and op=SUMS:
  - The low nibble gets +6 if it is >9 or the half-carry is set.
  - Then the high nibble gets +6 (0x60 added) if the intermediate value is >0x99 or the binary carry is set.
  - The carry is forced to 1 when the high correction applies.
  - hc reports the binary half-carry.
- Not defined: daa is still a port but is ignored; SUMS is always binary. No daa_q storage is generated.

Decomposition:
Shared package alu_pkg holds:
- The op enum: OP_SUMS, OP_ANDS, OP_EORS, OP_ORS, OP_SRS.
- The reset constants.
- A packed flags struct {acr, avr, hc}.

One sub-module is natural:
- alu_bcd_adjust, the combinational decimal corrector, instantiated only under DECIMAL_MODE_EN.
- Operand latches, op latch and flag registers stay in alu_core.

Test Plan:
- Reset: hold res_n=0 with sb_add=1, sb_bus=0x55 -> alu_to_add=0x00, acr=avr=hc=0; on release with no strobes, the outputs stay at 0x00.
- Binary overflow: A=0x7F (sb_add), B=0x01 (db_add), sums, cin=0 -> alu_to_add=0x80 that cycle; next edge avr=1, acr=0, hc=1.
- Wrap and subtract: A=0xFF, B=0x01, sums, cin=0 -> 0x00 with acr=1. Then A=0x05, db_n_add with db=0x03, cin=1 -> 0x02 with acr=1.
- Bus conflict and hold:
  - db_add+adl_add with db=0xF0, adl=0x3C -> B=0x30.
  - ands with A=0xFF -> 0x30.
  - Next cycle with no strobes -> the result is still 0x30.
- Shift, op priority and clamp:
  - SRS with A=0x81, cin=1 -> 0xC0; next edge acr=1.
  - sums+ors asserted together -> SUMS is selected.
  - zero_add+sb_add -> A=0x00.
- Decimal (with DECIMAL_MODE_EN):
  - A=0x19, B=0x28, daa, sums -> 0x47, acr=0.
  - A=0x99, B=0x01 -> 0x00, acr=1.
  - Without the macro, the same stimulus -> 0x41 and 0x9A.
